// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the instruction-memory boot loader:
//   - state_e      : loader frame-parsing states
//   - ERR_*        : values reported on ErrCode
//   - DEFAULT_MAGIC: default frame start byte
//   - word_addr()  : word index to word-aligned byte address
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

    localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

    // Byte address of a 32-bit word: {index, 2'b00}, zero-extended.
    function automatic logic [31:0] word_addr(input logic [15:0] idx);
        return {14'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// -----------------------------------------------------------------------------
// imem_word_packer
//   Assembles little-endian 32-bit words from a byte stream.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     clear_i       : restart; drops any partially assembled word
//     valid_i       : byte_i is a payload byte to shift in this cycle
//     byte_i[7:0]   : payload byte
//     word_o[31:0]  : assembled word, valid while word_ready_o is high
//     word_ready_o  : high in the cycle the 4th byte of a word is presented
// -----------------------------------------------------------------------------
module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [1:0]  cnt_q,   cnt_d;
    logic [23:0] shift_q, shift_d;

    // Only the first three bytes are stored; the fourth is taken straight
    // from the input so the word is complete in the cycle it arrives.
    assign word_o       = {byte_i, shift_q};
    assign word_ready_o = valid_i && (cnt_q == 2'd3);

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (valid_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {byte_i, shift_q[23:8]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time instruction memory writer. Parses frames
//     MAGIC, LEN_LO, LEN_HI, 4*N payload bytes (LSB first per word), CSUM
//   writes each word at consecutive word-aligned addresses and keeps the CPU
//   held until a frame has been fully written and its checksum verified.
//   Parameters:
//     DEPTH_WORDS   : instruction memory capacity in words
//     MAGIC         : frame start byte
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     ByteIn/Valid  : input byte stream
//     ByteReady     : always 1 once out of reset (no back-pressure)
//     WrEn/Addr/Data: registered one-cycle write to instruction memory
//     CpuHold       : holds the core in reset unless a load has completed
//     Done/Error    : last frame verified / rejected
//     ErrCode       : ERR_NONE, ERR_LEN or ERR_CSUM
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [7:0]  MAGIC       = DEFAULT_MAGIC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic        WrEn,
    output logic [31:0] WrAddr,
    output logic [31:0] WrData,
    output logic        CpuHold,
    output logic        Done,
    output logic        Error,
    output logic [1:0]  ErrCode
);

    state_e      state_q,   state_d;
    logic [15:0] len_q,     len_d;
    logic [15:0] widx_q,    widx_d;
    logic [7:0]  csum_q,    csum_d;
    logic        wr_en_q,   wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [1:0]  code_q,    code_d;
    logic        ready_q;

    logic        accept;
    logic        restart;
    logic [15:0] len_full;
    logic [31:0] word;
    logic        word_ready;

    assign accept   = ByteValid && ready_q;
    assign len_full = {ByteIn, len_q[7:0]};

    imem_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (restart),
        .valid_i      (accept && (state_q == DATA)),
        .byte_i       (ByteIn),
        .word_o       (word),
        .word_ready_o (word_ready)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        widx_d    = widx_q;
        csum_d    = csum_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        code_d    = code_q;
        restart   = 1'b0;

        if (accept) begin
            unique case (state_q)
                IDLE, DONE, ERR: begin
                    // Counters are cleared as MAGIC is taken, so LEN_LO is
                    // always entered with a clean word index and checksum.
                    if (ByteIn == MAGIC) begin
                        state_d = LEN_LO;
                        widx_d  = '0;
                        csum_d  = '0;
                        code_d  = ERR_NONE;
                        restart = 1'b1;
                    end
                end
                LEN_LO: begin
                    len_d   = {8'h00, ByteIn};
                    state_d = LEN_HI;
                end
                LEN_HI: begin
                    len_d = len_full;
                    if (32'(len_full) > DEPTH_WORDS) begin
                        state_d = ERR;
                        code_d  = ERR_LEN;
                    end else if (len_full == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    csum_d = csum_q + ByteIn;
                    if (word_ready) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = word_addr(widx_q);
                        wr_data_d = word;
                        widx_d    = widx_q + 16'd1;
                        if (widx_d == len_q) begin
                            state_d = CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (ByteIn == csum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERR;
                        code_d  = ERR_CSUM;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            widx_q    <= '0;
            csum_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            code_q    <= ERR_NONE;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            widx_q    <= widx_d;
            csum_q    <= csum_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            code_q    <= code_d;
            ready_q   <= 1'b1;
        end
    end

    // Status flags decode the registered state, so CpuHold falls exactly
    // when Done rises and both revert the cycle after a restarting MAGIC.
    assign ByteReady = ready_q;
    assign WrEn      = wr_en_q;
    assign WrAddr    = wr_addr_q;
    assign WrData    = wr_data_q;
    assign Done      = (state_q == DONE);
    assign Error     = (state_q == ERR);
    assign CpuHold   = (state_q != DONE);
    assign ErrCode   = code_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader. A frame-level reference model parses
//   each byte stream as a whole and predicts the writes and final status.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ByteIn = 8'h00;
    logic        ByteValid = 1'b0;
    logic        ByteReady;
    logic        WrEn;
    logic [31:0] WrAddr;
    logic [31:0] WrData;
    logic        CpuHold;
    logic        Done;
    logic        Error;
    logic [1:0]  ErrCode;

    imem_loader #(
        .DEPTH_WORDS (DEPTH),
        .MAGIC       (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ByteIn    (ByteIn),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady),
        .WrEn      (WrEn),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .CpuHold   (CpuHold),
        .Done      (Done),
        .Error     (Error),
        .ErrCode   (ErrCode)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed writes, sampled on the falling edge.
    logic [63:0] got_w[$];
    always @(negedge clk) begin
        if (WrEn) got_w.push_back({WrAddr, WrData});
    end

    // Reference model results.
    logic [63:0] exp_w[$];
    bit          exp_done;
    bit          exp_err;
    logic [1:0]  exp_code;

    // Parse one complete frame (optionally preceded by non-MAGIC junk).
    task automatic model(input logic [7:0] q[$]);
        int i;
        int n;
        int base;
        logic [7:0]  s;
        exp_w.delete();
        exp_done = 0;
        exp_err  = 0;
        exp_code = 2'd0;
        i = 0;
        while (i < q.size() && q[i] != 8'hA5) i++;
        n = int'(q[i+1]) + 256 * int'(q[i+2]);
        if (n > int'(DEPTH)) begin
            exp_err  = 1;
            exp_code = 2'd1;
            return;
        end
        s = 8'h00;
        for (int k = 0; k < n; k++) begin
            base = i + 3 + 4 * k;
            s = s + q[base] + q[base+1] + q[base+2] + q[base+3];
            exp_w.push_back({32'(k * 4), q[base+3], q[base+2], q[base+1], q[base]});
        end
        if (q[i + 3 + 4 * n] == s) begin
            exp_done = 1;
        end else begin
            exp_err  = 1;
            exp_code = 2'd2;
        end
    endtask

    // Drive one byte after 0..gmax idle cycles; returns 1 time unit after
    // the edge that accepted it.
    task automatic send_byte(input logic [7:0] b, input int gmax);
        int gaps;
        gaps = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
        repeat (gaps) begin
            @(posedge clk);
            #1;
        end
        ByteIn    = b;
        ByteValid = 1'b1;
        @(posedge clk);
        #1;
        ByteValid = 1'b0;
        ByteIn    = 8'($urandom);
    endtask

    logic [7:0] frm[$];

    // Build a frame of n random words with junk prefix; overflow frames
    // stop after LEN_HI.
    task automatic make_frame(input int n, input bit bad, input int junk);
        logic [7:0] s;
        logic [7:0] b;
        frm.delete();
        for (int j = 0; j < junk; j++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            frm.push_back(b);
        end
        frm.push_back(8'hA5);
        frm.push_back(8'(n));
        frm.push_back(8'(n >> 8));
        if (n > int'(DEPTH)) return;
        s = 8'h00;
        for (int j = 0; j < 4 * n; j++) begin
            b = 8'($urandom);
            s = s + b;
            frm.push_back(b);
        end
        frm.push_back(bad ? s + 8'(1 + $urandom_range(0, 254)) : s);
    endtask

    task automatic run_frame(input logic [7:0] q[$], input int gmax, input string tag);
        int first_bad;
        got_w.delete();
        model(q);
        foreach (q[k]) send_byte(q[k], gmax);
        // Status must reflect the deciding byte in the very next cycle.
        check({tag, "_done_now"}, 64'(Done), 64'(exp_done));
        check({tag, "_err_now"},  64'(Error), 64'(exp_err));
        check({tag, "_hold_now"}, 64'(CpuHold), 64'(!exp_done));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_nwr"}, 64'(got_w.size()), 64'(exp_w.size()));
        first_bad = -1;
        for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
            if (got_w[k] !== exp_w[k]) begin
                first_bad = k;
                break;
            end
        end
        if (first_bad >= 0)
            check({tag, "_wr"}, got_w[first_bad], exp_w[first_bad]);
        else if (exp_w.size() > 0 && got_w.size() > 0)
            check({tag, "_wr_last"}, got_w[got_w.size()-1], exp_w[exp_w.size()-1]);
        if (exp_w.size() > 0)
            check({tag, "_hold_wr"}, {WrAddr, WrData}, exp_w[exp_w.size()-1]);
        check({tag, "_done"}, 64'(Done), 64'(exp_done));
        check({tag, "_err"},  64'(Error), 64'(exp_err));
        check({tag, "_code"}, 64'(ErrCode), 64'(exp_code));
        check({tag, "_hold"}, 64'(CpuHold), 64'(!exp_done));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(ByteReady), 64'(0));
        check({tag, "_wren"},  64'(WrEn), 64'(0));
        check({tag, "_addr"},  64'(WrAddr), 64'(0));
        check({tag, "_data"},  64'(WrData), 64'(0));
        check({tag, "_hold"},  64'(CpuHold), 64'(1));
        check({tag, "_done"},  64'(Done), 64'(0));
        check({tag, "_err"},   64'(Error), 64'(0));
        check({tag, "_code"},  64'(ErrCode), 64'(0));
    endtask

    logic [7:0] two_word[$];

    initial begin
        two_word = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                     8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 64'(ByteReady), 64'(1));

        // Two-word load with known contents.
        run_frame(two_word, 0, "two_word");
        check("two_word_w0", got_w.size() > 0 ? got_w[0] : 64'hX, 64'h0000_0000_0000_0013);
        check("two_word_w1", got_w.size() > 1 ? got_w[1] : 64'hX, 64'h0000_0004_0010_0093);

        // Bad checksum: writes still land, frame rejected.
        frm = two_word;
        frm[11] = 8'hB7;
        run_frame(frm, 0, "bad_csum");

        // Length overflow by one word.
        frm = '{8'hA5, 8'h01, 8'h04};
        run_frame(frm, 0, "ovf");

        // Junk then an empty frame.
        frm = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame(frm, 0, "empty");

        // Gapped stream.
        run_frame(two_word, 5, "gapped");

        // Largest legal frame, then the first illegal length.
        make_frame(int'(DEPTH), 0, 0);
        run_frame(frm, 0, "full_depth");
        make_frame(int'(DEPTH) + 1, 0, 1);
        run_frame(frm, 0, "depth_plus1");

        // Random frames.
        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 7) == 0)
                make_frame(int'($urandom_range(DEPTH + 1, 65535)), 0, int'($urandom_range(0, 3)));
            else
                make_frame(int'($urandom_range(0, 8)), ($urandom_range(0, 3) == 0),
                           int'($urandom_range(0, 3)));
            run_frame(frm, int'($urandom_range(0, 2)), $sformatf("rnd%0d", r));
        end

        // Reset mid-frame, then reload.
        for (int k = 0; k < 6; k++) send_byte(two_word[k], 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_midrst", 64'(ByteReady), 64'(1));
        run_frame(two_word, 0, "reload");

        // A further MAGIC after Done re-holds the CPU.
        send_byte(8'hA5, 0);
        check("restart_hold", 64'(CpuHold), 64'(1));
        check("restart_done", 64'(Done), 64'(0));
        check("restart_err",  64'(Error), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
